// File: rtl/dataram_master_if.sv
// Pin-level bus between the data RAM access sequencer (master) and the 8051 internal data RAM (slave).
// Chip select is active low; rw high means read; bb high means byte access.
interface dataram_master_if;
    logic       mem_cs_n;
    logic       mem_rw;
    logic       mem_bb;
    logic [7:0] mem_addr;
    logic [7:0] mem_pos;
    logic [7:0] mem_din;
    logic       mem_bin;
    logic [7:0] mem_dout;
    logic       mem_bout;

    modport master (
        output mem_cs_n, mem_rw, mem_bb, mem_addr, mem_pos, mem_din, mem_bin,
        input  mem_dout, mem_bout
    );

    modport slave (
        input  mem_cs_n, mem_rw, mem_bb, mem_addr, mem_pos, mem_din, mem_bin,
        output mem_dout, mem_bout
    );
endinterface

// File: rtl/dataram_master.sv
// Sequences byte/bit read, write and read-modify-write ops into the 8051 internal data RAM.
// Latency accept-to-done: error 1, write 2, read RD_CYCLES+1, RMW RD_CYCLES+2 cycles.
// No backpressure: start is ignored while busy, one op in flight, done is a single-cycle pulse.
module dataram_master #(
    parameter int RD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] op,
    input  logic       use_rn,
    input  logic [1:0] rs,
    input  logic [2:0] rn,
    input  logic [7:0] addr_in,
    input  logic [7:0] wdata,
    input  logic       wbit,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] rdata,
    output logic       rbit,
    dataram_master_if.master mem
);

    localparam logic [2:0] OP_RDB    = 3'b000;
    localparam logic [2:0] OP_WRB    = 3'b001;
    localparam logic [2:0] OP_RDBIT  = 3'b010;
    localparam logic [2:0] OP_WRBIT  = 3'b011;
    localparam logic [2:0] OP_CPLBIT = 3'b100;
    localparam logic [2:0] OP_INCB   = 3'b101;
    localparam logic [2:0] OP_DECB   = 3'b110;
    localparam logic [2:0] OP_RSV    = 3'b111;

    localparam logic [7:0] RD_LAST = 8'(RD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

    state_t     state;
    logic [2:0] op_q;
    logic [7:0] rd_cnt;
    logic       bit_op;
    logic       bad_op;
    logic       wr_only;

    assign bit_op  = (op == OP_RDBIT) || (op == OP_WRBIT) || (op == OP_CPLBIT);
    assign bad_op  = (op == OP_RSV) || (bit_op && addr_in[7]);
    assign wr_only = (op == OP_WRB) || (op == OP_WRBIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            op_q         <= OP_RDB;
            rd_cnt       <= 8'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            rdata        <= 8'd0;
            rbit         <= 1'b0;
            mem.mem_cs_n <= 1'b1;
            mem.mem_rw   <= 1'b1;
            mem.mem_bb   <= 1'b1;
            mem.mem_addr <= 8'd0;
            mem.mem_pos  <= 8'd0;
            mem.mem_din  <= 8'd0;
            mem.mem_bin  <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        busy <= 1'b1;
                        if (bad_op) begin
                            // Rejected ops finish immediately without touching the RAM pins.
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            // Bit address: 0x00-0x7F map onto bytes 0x20-0x2F, eight bits each.
                            if (bit_op) begin
                                mem.mem_addr <= 8'h20 + {4'b0000, addr_in[6:3]};
                                mem.mem_pos  <= 8'd1 << addr_in[2:0];
                            end else begin
                                mem.mem_addr <= use_rn ? {3'b000, rs, rn} : addr_in;
                                mem.mem_pos  <= 8'd0;
                            end
                            mem.mem_bb   <= ~bit_op;
                            mem.mem_din  <= wdata;
                            mem.mem_bin  <= wbit;
                            mem.mem_cs_n <= 1'b0;
                            rd_cnt       <= 8'd0;
                            if (wr_only) begin
                                state      <= WR;
                                mem.mem_rw <= 1'b0;
                            end else begin
                                state      <= RD;
                                mem.mem_rw <= 1'b1;
                            end
                        end
                    end
                end

                RD: begin
                    if (rd_cnt == RD_LAST) begin
                        case (op_q)
                            OP_RDB: begin
                                rdata        <= mem.mem_dout;
                                state        <= DONE;
                                mem.mem_cs_n <= 1'b1;
                                done         <= 1'b1;
                            end
                            OP_RDBIT: begin
                                rbit         <= mem.mem_bout;
                                state        <= DONE;
                                mem.mem_cs_n <= 1'b1;
                                done         <= 1'b1;
                            end
                            OP_CPLBIT: begin
                                mem.mem_bin <= ~mem.mem_bout;
                                mem.mem_rw  <= 1'b0;
                                state       <= WR;
                            end
                            OP_INCB: begin
                                mem.mem_din <= mem.mem_dout + 8'd1;
                                mem.mem_rw  <= 1'b0;
                                state       <= WR;
                            end
                            default: begin
                                mem.mem_din <= mem.mem_dout - 8'd1;
                                mem.mem_rw  <= 1'b0;
                                state       <= WR;
                            end
                        endcase
                    end else begin
                        rd_cnt <= rd_cnt + 8'd1;
                    end
                end

                WR: begin
                    // RMW results are reported from the value just written.
                    if (op_q == OP_INCB || op_q == OP_DECB) begin
                        rdata <= mem.mem_din;
                    end
                    if (op_q == OP_CPLBIT) begin
                        rbit <= mem.mem_bin;
                    end
                    state        <= DONE;
                    mem.mem_cs_n <= 1'b1;
                    mem.mem_rw   <= 1'b1;
                    done         <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dataram_master.md
Name: dataram_master

Overview:
- Access sequencer that initiates every transaction into the 8051 internal data RAM (byte/bit memory with active-low CS, RW high = read, Bb high = byte).
- Takes a one-cycle op request from the core's execute stage and translates it into the RAM's pin protocol:
  - 8051 bit address to byte address plus one-hot position.
  - Rn/bank selection to a direct address.
- Sequences read, write and read-modify-write, then returns data with a done pulse.

Parameters:
- RD_CYCLES, 2, cycles mem_cs_n is held low with mem_rw=1 on a read; data is sampled at the last of these edges (minimum 2).

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  op request; accepted only when busy=0
- op  in  3  000 RDB, 001 WRB, 010 RDBIT, 011 WRBIT, 100 CPLBIT, 101 INCB, 110 DECB, 111 reserved
- use_rn  in  1  byte ops only: address = {3'b000, rs, rn}; addr_in is ignored
- rs  in  2  register bank select (PSW.RS1:RS0)
- rn  in  3  register number R0..R7
- addr_in  in  8  direct byte address (byte ops) or 8051 bit address (bit ops)
- wdata  in  8  byte write data
- wbit  in  1  bit write data
- busy  out  1  high from the accept edge through the DONE state
- done  out  1  one-cycle pulse; rdata/rbit/err valid in that cycle
- err  out  1  valid with done; op rejected
- rdata  out  8  RDB: read value; INCB/DECB: new value written
- rbit  out  1  RDBIT: read bit; CPLBIT: new bit written
- mem_cs_n  out  1  RAM chip select, active low
- mem_rw  out  1  1 = read, 0 = write
- mem_bb  out  1  1 = byte, 0 = bit
- mem_addr  out  8  RAM address
- mem_pos  out  8  one-hot bit position (bit ops), 0 for byte ops
- mem_din  out  8  RAM byte write data
- mem_bin  out  1  RAM bit write data
- mem_dout  in  8  RAM byte read data (Z when deselected)
- mem_bout  in  1  RAM bit read data

Behaviour:
- Registers and reset:
  - All outputs are registered.
  - Reset values: mem_cs_n=1, mem_rw=1, mem_bb=1, mem_addr=0, mem_pos=0, mem_din=0, mem_bin=0, busy=0, done=0, err=0, rdata=0, rbit=0. State = IDLE.
- Operand capture: op and all operands are latched on the accept edge (start=1 in IDLE). start is ignored in every other state, including DONE.
- Address translation:
  - Bit ops: addr_in[7]=1 (SFR bit space) is an error.
  - Otherwise mem_addr = 8'h20 + addr_in[6:3], and mem_pos = 1 << addr_in[2:0].
  - Byte ops: mem_addr = use_rn ? {3'b000, rs, rn} : addr_in, and mem_pos = 0.
- State machine: IDLE, RD, WR, DONE.
  - IDLE -> RD: RDB, RDBIT, CPLBIT, INCB, DECB.
  - IDLE -> WR: WRB, WRBIT.
  - IDLE -> DONE with err=1, no RAM access (mem_cs_n stays 1): op=111, or a bit op with addr_in[7]=1.
- RD state:
  - Drives mem_cs_n=0, mem_rw=1 for RD_CYCLES cycles.
  - On the final edge, captures mem_dout or mem_bout.
  - Then goes to DONE for RDB/RDBIT, or to WR for CPLBIT/INCB/DECB.
- WR state:
  - One cycle with mem_cs_n=0, mem_rw=0; the RAM commits on the edge that ends WR.
  - Write data:
    - WRB: mem_din = wdata.
    - WRBIT: mem_bin = wbit.
    - CPLBIT: mem_bin = ~captured bit.
    - INCB: mem_din = captured + 1, modulo 256 (FF -> 00).
    - DECB: mem_din = captured - 1 (00 -> FF).
  - Goes to DONE.
- DONE state:
  - One cycle: mem_cs_n=1, mem_rw=1, done=1, err as decided.
  - rdata/rbit are updated for read and RMW ops and hold their value until the next done.
  - Returns to IDLE; busy drops the following cycle.
- Latency from accept edge to done-high cycle (RD_CYCLES=2):
  - write: 2 cycles
  - read: 3 cycles
  - RMW: 4 cycles
  - error: 1 cycle
- mem_cs_n is never low outside RD/WR. mem_rw transitions from 1 to 0 only with mem_cs_n low, going from RD into WR of an RMW op. No back-to-back access without an IDLE cycle.
- Reset mid-operation: return to IDLE with reset values on the next edge, and no done pulse. A write whose WR cycle coincides with the rst edge may commit; no later access is issued.

Test Plan:
- Reset, then WRB addr_in=8'h45 wdata=8'hA5, followed by RDB 8'h45 -> done at cycle 2 and cycle 3 respectively; rdata=8'hA5; err=0.
- WRBIT addr_in=8'h0B wbit=1 -> mem_addr=8'h21, mem_pos=8'h08, mem_bb=0. Then RDBIT 8'h0B -> rbit=1. Then CPLBIT 8'h0B -> rbit=0 and the RAM bit reads back 0.
- rs=2'b10, rn=3'd5, use_rn=1, WRB wdata=8'hFF, then INCB -> mem_addr=8'h15, rdata=8'h00 (wrap). Then DECB -> rdata=8'hFF.
- RDBIT addr_in=8'h90 and op=111 -> done after 1 cycle with err=1, mem_cs_n never low.
- Pulse start every cycle during an INCB -> only the first start is accepted; exactly one done pulse, 4 cycles after accept.
- Assert rst during the RD phase of DECB -> no done pulse, outputs return to reset values, RAM byte unchanged.
